// File: rtl/muldiv_pkg.sv
// muldiv_pkg: operation and state encodings shared by the multiply/divide unit
package muldiv_pkg;
  typedef enum logic [1:0] {
    MD_OP_MULT  = 2'b00,
    MD_OP_MULTU = 2'b01,
    MD_OP_DIV   = 2'b10,
    MD_OP_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10,
    MD_DONE = 2'b11
  } md_state_t;

  function automatic logic op_signed(input logic [1:0] op);
    return !op[0];
  endfunction

  function automatic logic op_div(input logic [1:0] op);
    return op[1];
  endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, shift-add multiply or restoring divide
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] low,
  input  logic [WIDTH-1:0] operand,
  input  logic             div,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] low_next
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;

  // multiply shifts {carry,acc,low} right; divide shifts {acc,low} left and keeps the difference if no borrow
  always_comb begin
    sum      = {1'b0, acc} + (low[0] ? {1'b0, operand} : '0);
    sh       = {acc, low[WIDTH-1]};
    diff     = sh - {1'b0, operand};
    acc_next = div ? (diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
    low_next = div ? {low[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], low[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply/divide producing HI/LO
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  md_state_t state, state_next;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] acc, low, divisor, acc_step, low_step;
  logic [WIDTH-1:0] mag_a, mag_b, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod;
  logic is_div, neg_q, neg_r, sa, sb, b_zero, accept;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .low     (low),
    .operand (divisor),
    .div     (is_div),
    .acc_next(acc_step),
    .low_next(low_step)
  );

  assign busy = (state == MD_RUN) || (state == MD_FIX);
  assign done = state == MD_DONE;

  // operand magnitudes at accept time and sign-corrected results at FIX time
  always_comb begin
    sa     = op_signed(op) & inA[WIDTH-1];
    sb     = op_signed(op) & inB[WIDTH-1];
    mag_a  = sa ? -inA : inA;
    mag_b  = sb ? -inB : inB;
    b_zero = inB == '0;
    accept = start && (state == MD_IDLE || state == MD_DONE);
    prod   = neg_q ? -{acc, low} : {acc, low};
    fix_hi = is_div ? (neg_r ? -acc : acc) : prod[2*WIDTH-1:WIDTH];
    fix_lo = is_div ? (neg_q ? -low : low) : prod[WIDTH-1:0];
  end

  // next state: cancel beats completion, divide by zero skips straight to DONE
  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE, MD_DONE: state_next = accept ? ((op_div(op) && b_zero) ? MD_DONE : MD_RUN) : MD_IDLE;
      MD_RUN:           state_next = cancel ? MD_IDLE : ((cnt == CW'(WIDTH - 1)) ? MD_FIX : MD_RUN);
      MD_FIX:           state_next = cancel ? MD_IDLE : MD_DONE;
      default:          state_next = MD_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= MD_IDLE;
    else state <= state_next;
  end

  // operand latch, iteration registers and HI/LO result registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      acc         <= '0;
      low         <= '0;
      divisor     <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else if (accept) begin
      cnt         <= '0;
      acc         <= '0;
      low         <= mag_a;
      divisor     <= mag_b;
      is_div      <= op_div(op);
      neg_q       <= sa ^ sb;
      neg_r       <= sa;
      div_by_zero <= op_div(op) && b_zero;
      if (op_div(op) && b_zero) begin
        hi <= inA;
        lo <= '1;
      end
    end else if (state == MD_RUN && !cancel) begin
      acc <= acc_step;
      low <= low_step;
      cnt <= cnt + CW'(1);
    end else if (state == MD_FIX && !cancel) begin
      hi <= fix_hi;
      lo <= fix_lo;
    end
  end
endmodule
